dht11_reader: RTL and testbench

Single-wire protocol controller for the DHT11 humidity/temperature sensor. Sits directly upstream of the bidirectional pad buffer and drives its direction and send-value inputs. Reads the sensor's returned line back through that buffer. On each START request it issues the host start pulse, decodes the sensor's 40-bit frame by measuring pulse widths, and presents humidity and temperature bytes with DONE/ERROR status.

---
 rtl/dht11_reader.sv | 144 ++++++++++++++
 tb/tb_dht11_reader.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/dht11_reader.sv
// DHT11 single-wire reader: host start pulse, pulse-width bit decode, 40-bit frame capture.
// Optional checksum validation is enabled by defining DHT_CHECKSUM_EN.
module dht11_reader #(
  parameter int CLK_FREQ_HZ   = 50_000_000,
  parameter int START_LOW_US  = 18000,
  parameter int BIT_THRESH_US = 40,
  parameter int TIMEOUT_US    = 200
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  output logic       DIR,
  output logic       SEND,
  input  logic       READ,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERROR,
  output logic [7:0] HUM_INT,
  output logic [7:0] HUM_DEC,
  output logic [7:0] TEMP_INT,
  output logic [7:0] TEMP_DEC
);

  localparam int DIV = CLK_FREQ_HZ / 1_000_000;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX   = PW'(DIV - 1);
  localparam logic [14:0]   T_START   = 15'(START_LOW_US - 1);
  localparam logic [14:0]   T_TIMEOUT = 15'(TIMEOUT_US - 1);
  localparam logic [14:0]   T_THRESH  = 15'(BIT_THRESH_US);

  typedef enum logic [3:0] {
    S_IDLE, S_START_LOW, S_RELEASE, S_RESP_LOW, S_RESP_HIGH,
    S_BIT_LOW, S_BIT_HIGH, S_CHECK, S_FINISH
  } state_t;

  state_t        state_q, state_d;
  logic          rd_m_q, rd_s_q, rd_prev_q;
  logic [PW-1:0] pre_q;
  logic [14:0]   timer_q;
  logic [39:0]   sh_q;
  logic [5:0]    cnt_q;
  logic          rise, fall, tick, timeout, frame_ok, wait_st;

  assign SEND = 1'b0;
  assign rise = rd_s_q & ~rd_prev_q;
  assign fall = ~rd_s_q & rd_prev_q;
  assign tick = (pre_q == PRE_MAX);

`ifdef DHT_CHECKSUM_EN
  logic [7:0] sum;
  assign sum      = sh_q[39:32] + sh_q[31:24] + sh_q[23:16] + sh_q[15:8];
  assign frame_ok = (sum == sh_q[7:0]);
`else
  assign frame_ok = 1'b1;
`endif

  // Line idles high through the pull-up, so the synchronizer resets high
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_m_q    <= 1'b1;
      rd_s_q    <= 1'b1;
      rd_prev_q <= 1'b1;
    end else begin
      rd_m_q    <= READ;
      rd_s_q    <= rd_m_q;
      rd_prev_q <= rd_s_q;
    end
  end

  assign wait_st = (state_q == S_RELEASE) || (state_q == S_RESP_LOW) ||
                   (state_q == S_RESP_HIGH) || (state_q == S_BIT_LOW) ||
                   (state_q == S_BIT_HIGH);
  // Terminal counts fire on the tick that completes the interval, giving exact durations
  assign timeout = wait_st && tick && (timer_q == T_TIMEOUT);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (START) state_d = S_START_LOW;
      S_START_LOW: if (tick && timer_q == T_START) state_d = S_RELEASE;
      S_RELEASE:   if (fall) state_d = S_RESP_LOW;
      S_RESP_LOW:  if (rise) state_d = S_RESP_HIGH;
      S_RESP_HIGH: if (fall) state_d = S_BIT_LOW;
      S_BIT_LOW:   if (rise) state_d = S_BIT_HIGH;
      S_BIT_HIGH:  if (fall) state_d = (cnt_q == 6'd39) ? S_CHECK : S_BIT_LOW;
      S_CHECK:     state_d = S_FINISH;
      S_FINISH:    state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
    if (timeout) state_d = S_FINISH;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      pre_q    <= '0;
      timer_q  <= '0;
      sh_q     <= '0;
      cnt_q    <= '0;
      DIR      <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      ERROR    <= 1'b0;
      HUM_INT  <= '0;
      HUM_DEC  <= '0;
      TEMP_INT <= '0;
      TEMP_DEC <= '0;
    end else begin
      state_q <= state_d;
      DIR     <= (state_d == S_START_LOW);
      BUSY    <= (state_d != S_IDLE);
      DONE    <= (state_d == S_FINISH);
      if (state_d != state_q) begin
        pre_q   <= '0;
        timer_q <= '0;
      end else begin
        pre_q <= tick ? '0 : pre_q + 1'b1;
        if (tick) timer_q <= timer_q + 15'd1;
      end
      if (state_q == S_IDLE && state_d == S_START_LOW) begin
        ERROR <= 1'b0;
        sh_q  <= '0;
        cnt_q <= '0;
      end
      if (state_q == S_BIT_HIGH && (state_d == S_BIT_LOW || state_d == S_CHECK)) begin
        sh_q  <= {sh_q[38:0], (timer_q > T_THRESH)};
        cnt_q <= cnt_q + 6'd1;
      end
      if (timeout) ERROR <= 1'b1;
      if (state_q == S_CHECK) begin
        if (frame_ok) begin
          HUM_INT  <= sh_q[39:32];
          HUM_DEC  <= sh_q[31:24];
          TEMP_INT <= sh_q[23:16];
          TEMP_DEC <= sh_q[15:8];
          ERROR    <= 1'b0;
        end else begin
          ERROR    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dht11_reader.sv
// Directed bench for dht11_reader at 1 MHz with a 20 us start pulse and a simple sensor model.
module tb_dht11_reader;

  logic       CLK = 1'b0;
  logic       RST, START, line;
  logic       DIR, SEND, BUSY, DONE, ERROR;
  logic [7:0] HUM_INT, HUM_DEC, TEMP_INT, TEMP_DEC;
  logic       rd;

  int checks = 0, errs = 0;
  int cyc = 0, done_cnt = 0, done_cyc = 0;

  always #5 CLK = ~CLK;

  // Pad model: host drives SEND when DIR=1, otherwise the sensor owns the line
  assign rd = DIR ? SEND : line;

  dht11_reader #(
    .CLK_FREQ_HZ(1_000_000), .START_LOW_US(20), .BIT_THRESH_US(40), .TIMEOUT_US(200)
  ) dut (
    .CLK(CLK), .RST(RST), .START(START), .DIR(DIR), .SEND(SEND), .READ(rd),
    .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR), .HUM_INT(HUM_INT), .HUM_DEC(HUM_DEC),
    .TEMP_INT(TEMP_INT), .TEMP_DEC(TEMP_DEC)
  );

  always @(posedge CLK) cyc++;
  always @(negedge CLK) if (DONE === 1'b1) begin done_cnt++; done_cyc = cyc; end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    line = v;
    repeat (n) @(negedge CLK);
  endtask

  task automatic pulse_start();
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic wait_release();
    int k = 0;
    while (DIR === 1'b1 && k < 200) begin k++; @(negedge CLK); end
    chk("dir_release", DIR, 1'b0);
  endtask

  // Sensor reply: response pair, then nbits data bits; bit stuck_at is held high 250 us
  task automatic send_bits(input logic [39:0] f, input int nbits, input int stuck_at,
                           output int rise_cyc);
    rise_cyc = 0;
    hold(1'b1, 10); hold(1'b0, 80); hold(1'b1, 80);
    for (int k = 0; k < nbits; k++) begin
      hold(1'b0, 50);
      if (k == stuck_at) begin
        rise_cyc = cyc;
        hold(1'b1, 250);
        return;
      end
      hold(1'b1, f[39-k] ? 70 : 26);
    end
    hold(1'b0, 50);
  endtask

  logic [39:0] good = {8'h37, 8'h00, 8'h19, 8'h00, 8'h50};
  logic [39:0] bad  = {8'h40, 8'h01, 8'h1A, 8'h02, 8'h51};

  initial begin
    int hi, n, dc, r;
    logic dir_seen;
    logic [7:0] exp_hum, exp_temp;
    RST = 1'b1; START = 1'b0; line = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_dir", DIR, 1'b0);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_done", DONE, 1'b0);
    chk("rst_error", ERROR, 1'b0);
    chk("rst_send", SEND, 1'b0);
    chk("rst_data", {HUM_INT, HUM_DEC, TEMP_INT, TEMP_DEC}, 32'h0);

    // Start pulse width, then a silent sensor
    pulse_start();
    chk("start_busy", BUSY, 1'b1);
    hi = 0;
    while (DIR === 1'b1 && hi < 100) begin hi++; @(negedge CLK); end
    chk("start_low_width", hi, 20);
    n = 0; dir_seen = 1'b0;
    while (DONE !== 1'b1 && n < 400) begin
      if (DIR !== 1'b0) dir_seen = 1'b1;
      n++; @(negedge CLK);
    end
    chk("silent_done_delay", n, 200);
    chk("silent_dir_low", dir_seen, 1'b0);
    chk("silent_error", ERROR, 1'b1);
    chk("silent_data", HUM_INT, 8'h00);

    // START coincident with DONE is dropped; held one more cycle it is taken
    START = 1'b1;
    @(negedge CLK);
    chk("start_on_done_ignored", BUSY, 1'b0);
    @(negedge CLK);
    START = 1'b0;
    chk("start_after_done_dir", DIR, 1'b1);
    chk("start_after_done_busy", BUSY, 1'b1);

    // Good frame
    dc = done_cnt;
    wait_release();
    send_bits(good, 40, -1, r);
    line = 1'b1;
    repeat (5) @(negedge CLK);
    chk("good_done_count", done_cnt - dc, 1);
    chk("good_error", ERROR, 1'b0);
    chk("good_hum_int", HUM_INT, 8'h37);
    chk("good_temp_int", TEMP_INT, 8'h19);
    chk("good_decs", {HUM_DEC, TEMP_DEC}, 16'h0000);
    chk("good_busy", BUSY, 1'b0);

    // Frame with a wrong checksum byte
    dc = done_cnt;
    pulse_start();
    wait_release();
    send_bits(bad, 40, -1, r);
    line = 1'b1;
    repeat (5) @(negedge CLK);
    chk("bad_done_count", done_cnt - dc, 1);
`ifdef DHT_CHECKSUM_EN
    chk("bad_error", ERROR, 1'b1);
    exp_hum = 8'h37; exp_temp = 8'h19;
`else
    chk("bad_error", ERROR, 1'b0);
    exp_hum = 8'h40; exp_temp = 8'h1A;
`endif
    chk("bad_hum_int", HUM_INT, exp_hum);
    chk("bad_temp_int", TEMP_INT, exp_temp);

    // Line stuck high during bit 12: BIT_HIGH is entered 3 cycles after the rise
    dc = done_cnt;
    pulse_start();
    wait_release();
    send_bits(good, 40, 12, r);
    line = 1'b1;
    repeat (5) @(negedge CLK);
    chk("stuck_done_count", done_cnt - dc, 1);
    chk("stuck_done_delay", done_cyc - r, 203);
    chk("stuck_error", ERROR, 1'b1);
    chk("stuck_hum_int", HUM_INT, exp_hum);
    chk("stuck_temp_int", TEMP_INT, exp_temp);

    // Asynchronous reset while driving the start pulse
    pulse_start();
    repeat (5) @(negedge CLK);
    chk("pre_rst_dir", DIR, 1'b1);
    #2 RST = 1'b1;
    #1 chk("rst_async_dir", DIR, 1'b0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    // Extra START while busy, then reset in BIT_LOW
    pulse_start();
    wait_release();
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    chk("busy_start_dir", DIR, 1'b0);
    chk("busy_start_busy", BUSY, 1'b1);
    dc = done_cnt;
    send_bits(good, 5, -1, r);
    chk("bitlow_busy", BUSY, 1'b1);
    #2 RST = 1'b1;
    #1 chk("rst_bitlow_busy", BUSY, 1'b0);
    chk("rst_bitlow_dir", DIR, 1'b0);
    @(negedge CLK);
    RST = 1'b0;
    line = 1'b1;
    repeat (300) @(negedge CLK);
    chk("rst_no_done", done_cnt - dc, 0);
    chk("rst_error_clear", ERROR, 1'b0);
    chk("rst_data_clear", {HUM_INT, TEMP_INT}, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
